// File: rtl/syn_fifo_rd_stream_if.sv
// Read-side bundle between syn_fifo and the prefetching stream adapter:
// the FIFO pull port plus the downstream valid/ready stream.
interface syn_fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_rd;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_dout, m_ready,
    output fifo_rd, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_dout, m_ready,
    input  fifo_rd, m_valid, m_data
  );
endinterface

// File: rtl/syn_fifo_rd_stream.sv
// Converts syn_fifo's rd/empty pull port (data one cycle after rd) into a
// valid/ready stream through a 3-entry prefetch ring, with flush and a transfer counter.
module syn_fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  syn_fifo_rd_stream_if.master bus,
  input  logic                 flush,
  output logic [CNT_WIDTH-1:0] xfer_cnt
);

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  logic                  vld_p1;
  logic [1:0]            occ_p2;
  logic [1:0]            wr_ptr_p2;
  logic [1:0]            rd_ptr_p2;
  logic [DATA_WIDTH-1:0] buf_p2 [3];

  logic room;
  logic capture;
  logic xfer;

  // Stage 0: issue. Only registered state feeds the strobe, so m_ready never reaches fifo_rd.
  assign room        = ({1'b0, occ_p2} + {2'b00, vld_p1}) <= 3'd2;
  assign bus.fifo_rd = !sys_rst && !flush && !bus.fifo_empty && room;

  assign capture     = vld_p1 && !flush;
  assign xfer        = bus.m_valid && bus.m_ready;

  assign bus.m_valid = (occ_p2 != 2'd0);
  assign bus.m_data  = bus.m_valid ? buf_p2[rd_ptr_p2] : '0;

  // Stage 1 -> 2: word returned by the FIFO lands in the ring; the stream drains it.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vld_p1    <= 1'b0;
      occ_p2    <= 2'd0;
      wr_ptr_p2 <= 2'd0;
      rd_ptr_p2 <= 2'd0;
      xfer_cnt  <= '0;
      for (int i = 0; i < 3; i++) buf_p2[i] <= '0;
    end else begin
      vld_p1 <= bus.fifo_rd;
      if (xfer) xfer_cnt <= xfer_cnt + CNT_WIDTH'(1);
      if (capture) buf_p2[wr_ptr_p2] <= bus.fifo_dout;
      if (flush) begin
        occ_p2    <= 2'd0;
        wr_ptr_p2 <= 2'd0;
        rd_ptr_p2 <= 2'd0;
      end else begin
        if (capture) wr_ptr_p2 <= ptr_inc(wr_ptr_p2);
        if (xfer)    rd_ptr_p2 <= ptr_inc(rd_ptr_p2);
        occ_p2 <= occ_p2 + {1'b0, capture} - {1'b0, xfer};
      end
    end
  end

endmodule

// File: tb/tb_syn_fifo_rd_stream.sv
// Bench for syn_fifo_rd_stream: FIFO model plus a queue-based reference of the
// adapter, cycle tables and hand-written corner sequences.
module tb_syn_fifo_rd_stream;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        flush   = 1'b0;
  logic [15:0] xfer_cnt;
  logic [3:0]  xfer_cnt4;

  syn_fifo_rd_stream_if #(.DATA_WIDTH(8)) bus  ();
  syn_fifo_rd_stream_if #(.DATA_WIDTH(8)) bus4 ();

  syn_fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus), .flush(flush), .xfer_cnt(xfer_cnt));

  syn_fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus4), .flush(flush), .xfer_cnt(xfer_cnt4));

  always #5 sys_clk = ~sys_clk;

  int passed = 0;
  int total  = 0;

  // FIFO storage: writer side owned by the stimulus, reader side by the FIFO process
  logic [7:0] mem [1024];
  int         wr_cnt = 0;
  int         rd_cnt = 0;

  // Reference: words the adapter holds, whether a word is on its way, handshakes seen
  logic [7:0] mbuf [$];
  logic       minf = 1'b0;
  int         mcnt = 0;
  logic [7:0] got  [$];
  int         bad_rd = 0;

  assign bus.fifo_empty  = (wr_cnt == rd_cnt);
  assign bus4.fifo_empty = bus.fifo_empty;
  assign bus4.fifo_dout  = bus.fifo_dout;
  assign bus4.m_ready    = bus.m_ready;

  function automatic logic exp_issue();
    return !flush && (wr_cnt != rd_cnt) && ((mbuf.size() + int'(minf)) <= 2);
  endfunction

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rd_cnt        <= wr_cnt;
      bus.fifo_dout <= '0;
      mbuf.delete();
      minf          <= 1'b0;
      mcnt          <= 0;
    end else begin
      minf <= exp_issue();
      if (mbuf.size() != 0 && bus.m_ready) begin
        void'(mbuf.pop_front());
        mcnt <= mcnt + 1;
      end
      if (minf && !flush) mbuf.push_back(bus.fifo_dout);
      if (flush) mbuf.delete();
      if (bus.fifo_rd) begin
        bus.fifo_dout <= mem[rd_cnt % 1024];
        rd_cnt        <= rd_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_cnt % 1024] = d;
    wr_cnt++;
  endtask

  // One cycle: drive on the falling edge, push words, then compare against the reference.
  task automatic step(input logic rdy, input logic fl, input int npush, input logic [7:0] first);
    @(negedge sys_clk);
    bus.m_ready = rdy;
    flush       = fl;
    for (int i = 0; i < npush; i++) push(first + 8'(i));
    #1;
    chk("m_valid",   int'(bus.m_valid), int'(mbuf.size() != 0));
    chk("m_data",    int'(bus.m_data),  (mbuf.size() != 0) ? int'(mbuf[0]) : 0);
    chk("fifo_rd",   int'(bus.fifo_rd), int'(exp_issue()));
    chk("xfer_cnt",  int'(xfer_cnt),    mcnt % 65536);
    chk("xfer_cnt4", int'(xfer_cnt4),   mcnt % 16);
    if (bus.fifo_rd && bus.fifo_empty) bad_rd++;
    if (bus.m_valid && rdy) got.push_back(bus.m_data);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst     = 1'b1;
    bus.m_ready = 1'b0;
    flush       = 1'b0;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    got.delete();
  endtask

  typedef struct {
    logic       rdy;
    int         npush;
    logic       exp_vld;
    logic [7:0] exp_data;
    logic       exp_rd;
    int         exp_cnt;
  } vec_t;

  function automatic vec_t mkv(input logic r, input int n, input logic v,
                               input logic [7:0] d, input logic rd, input int c);
    vec_t x;
    x.rdy = r; x.npush = n; x.exp_vld = v; x.exp_data = d; x.exp_rd = rd; x.exp_cnt = c;
    return x;
  endfunction

  vec_t tbl [19];
  logic pat [6];

  initial begin
    int base;
    bus.m_ready = 1'b0;

    // Backpressure cycle table: 8 words, stalled 10 cycles, then drained.
    tbl[0]  = mkv(1'b0, 8, 1'b0, 8'h00, 1'b1, 0);
    tbl[1]  = mkv(1'b0, 0, 1'b0, 8'h00, 1'b1, 0);
    tbl[2]  = mkv(1'b0, 0, 1'b1, 8'h31, 1'b1, 0);
    for (int i = 3; i < 10; i++) tbl[i] = mkv(1'b0, 0, 1'b1, 8'h31, 1'b0, 0);
    tbl[10] = mkv(1'b1, 0, 1'b1, 8'h31, 1'b0, 0);
    tbl[11] = mkv(1'b1, 0, 1'b1, 8'h32, 1'b1, 1);
    tbl[12] = mkv(1'b1, 0, 1'b1, 8'h33, 1'b1, 2);
    tbl[13] = mkv(1'b1, 0, 1'b1, 8'h34, 1'b1, 3);
    tbl[14] = mkv(1'b1, 0, 1'b1, 8'h35, 1'b1, 4);
    tbl[15] = mkv(1'b1, 0, 1'b1, 8'h36, 1'b1, 5);
    tbl[16] = mkv(1'b1, 0, 1'b1, 8'h37, 1'b0, 6);
    tbl[17] = mkv(1'b1, 0, 1'b1, 8'h38, 1'b0, 7);
    tbl[18] = mkv(1'b1, 0, 1'b0, 8'h00, 1'b0, 8);
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b0; pat[5] = 1'b1;

    // Asynchronous reset while two words are buffered and one is in flight
    do_reset();
    step(1'b1, 1'b0, 10, 8'h11);
    step(1'b1, 1'b0, 0, 8'h00);
    step(1'b1, 1'b0, 0, 8'h00);
    step(1'b1, 1'b0, 0, 8'h00);
    step(1'b0, 1'b0, 0, 8'h00);
    step(1'b0, 1'b0, 0, 8'h00);
    chk("pre_rst_cnt", int'(xfer_cnt), 2);
    #2 sys_rst = 1'b1;
    #1;
    chk("rst_m_valid",  int'(bus.m_valid), 0);
    chk("rst_fifo_rd",  int'(bus.fifo_rd), 0);
    chk("rst_xfer_cnt", int'(xfer_cnt),    0);
    chk("rst_m_data",   int'(bus.m_data),  0);
    @(negedge sys_clk);
    sys_rst = 1'b0;

    // Streaming 0x01..0x10 with m_ready held high
    do_reset();
    step(1'b1, 1'b0, 16, 8'h01);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 0, 8'h00);
    chk("stream_len", got.size(), 16);
    for (int i = 0; i < got.size() && i < 16; i++) chk("stream_data", int'(got[i]), i + 1);
    chk("stream_cnt", int'(xfer_cnt), 16);

    // Backpressure table
    do_reset();
    base = rd_cnt;
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].rdy, 1'b0, tbl[i].npush, 8'h31);
      chk("tbl_m_valid",  int'(bus.m_valid), int'(tbl[i].exp_vld));
      chk("tbl_m_data",   int'(bus.m_data),  int'(tbl[i].exp_data));
      chk("tbl_fifo_rd",  int'(bus.fifo_rd), int'(tbl[i].exp_rd));
      chk("tbl_xfer_cnt", int'(xfer_cnt),    tbl[i].exp_cnt);
      if (i == 9) chk("tbl_reads_stalled", rd_cnt - base, 3);
    end

    // Stall/resume pattern over 16 words
    do_reset();
    step(pat[0], 1'b0, 16, 8'h81);
    for (int i = 1; i < 48; i++) step(pat[i % 6], 1'b0, 0, 8'h00);
    chk("stall_len", got.size(), 16);
    for (int i = 0; i < got.size() && i < 16; i++) chk("stall_data", int'(got[i]), 8'h81 + i);

    // Flush with two buffered and one in flight, m_ready low
    do_reset();
    step(1'b0, 1'b0, 6, 8'h51);
    step(1'b0, 1'b0, 0, 8'h00);
    step(1'b0, 1'b0, 0, 8'h00);
    step(1'b0, 1'b1, 0, 8'h00);
    chk("flush_fifo_rd", int'(bus.fifo_rd), 0);
    chk("flush_data",    int'(bus.m_data),  8'h51);
    step(1'b0, 1'b0, 0, 8'h00);
    chk("post_flush_valid", int'(bus.m_valid), 0);
    chk("post_flush_cnt",   int'(xfer_cnt),    0);
    chk("post_flush_rd",    int'(bus.fifo_rd), 1);
    step(1'b0, 1'b0, 0, 8'h00);
    chk("refill_valid0", int'(bus.m_valid), 0);
    step(1'b0, 1'b0, 0, 8'h00);
    chk("refill_valid1", int'(bus.m_valid), 1);
    chk("refill_data",   int'(bus.m_data),  8'h54);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 0, 8'h00);
    chk("flush_len", got.size(), 3);
    for (int i = 0; i < got.size() && i < 3; i++) chk("flush_data_out", int'(got[i]), 8'h54 + i);
    // Handshake in the flush cycle is still counted
    step(1'b0, 1'b0, 2, 8'h61);
    step(1'b0, 1'b0, 0, 8'h00);
    step(1'b0, 1'b0, 0, 8'h00);
    step(1'b1, 1'b1, 0, 8'h00);
    step(1'b1, 1'b0, 0, 8'h00);
    chk("flush_hs_cnt",   int'(xfer_cnt),    4);
    chk("flush_hs_valid", int'(bus.m_valid), 0);

    // Counter wrap on the 4-bit instance
    do_reset();
    step(1'b1, 1'b0, 17, 8'hC0);
    for (int i = 0; i < 24; i++) step(1'b1, 1'b0, 0, 8'h00);
    chk("wrap_cnt4",  int'(xfer_cnt4), 1);
    chk("wrap_cnt16", int'(xfer_cnt),  17);

    // Randomized traffic against the reference
    do_reset();
    for (int i = 0; i < 400; i++)
      step(1'(($urandom % 4) != 0), 1'(($urandom % 24) == 0),
           (($urandom % 3) == 0) ? int'($urandom_range(1, 3)) : 0, 8'($urandom));

    chk("rd_while_empty", bad_rd, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1, "timeout");
  end

endmodule
